// File: rtl/rvfi_chk_pkg.sv
// rtl/rvfi_chk_pkg.sv - shared types and constants for the RVFI register checker
package rvfi_chk_pkg;

  localparam int NUM_REGS = 32;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_ORDER     = 3'd1,
    ERR_PC        = 3'd2,
    ERR_RS1       = 3'd3,
    ERR_RS2       = 3'd4,
    ERR_X0_WRITE  = 3'd5,
    ERR_POST_HALT = 3'd6
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/rvfi_shadow_rf.sv
// rtl/rvfi_shadow_rf.sv - shadow integer register file with per-register known bits
module rvfi_shadow_rf
  import rvfi_chk_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  output logic        rknown1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  output logic        rknown2
);

  logic [31:0]         regs [NUM_REGS];
  logic [NUM_REGS-1:0] known;

  // x0 is permanently known; its storage is never written and reads are forced to 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      known <= {{(NUM_REGS-1){1'b0}}, 1'b1};
    end else if (we && waddr != 5'd0) begin
      known[waddr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1  = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
  assign rknown1 = known[raddr1];
  assign rdata2  = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];
  assign rknown2 = known[raddr2];

endmodule

// File: rtl/rvfi_reg_checker.sv
// rtl/rvfi_reg_checker.sv - RVFI retirement checker: order, PC continuity, shadow register consistency
module rvfi_reg_checker
  import rvfi_chk_pkg::*;
#(
  parameter int CHECK_PC  = 1,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rvfi_valid,
  input  logic [63:0]          rvfi_order,
  input  logic                 rvfi_trap,
  input  logic                 rvfi_halt,
  input  logic                 rvfi_intr,
  input  logic [4:0]           rvfi_rs1_addr,
  input  logic [4:0]           rvfi_rs2_addr,
  input  logic [31:0]          rvfi_rs1_rdata,
  input  logic [31:0]          rvfi_rs2_rdata,
  input  logic [4:0]           rvfi_rd_addr,
  input  logic [31:0]          rvfi_rd_wdata,
  input  logic [31:0]          rvfi_pc_rdata,
  input  logic [31:0]          rvfi_pc_wdata,
  output logic                 err_valid,
  output logic [2:0]           err_code,
  output logic [63:0]          err_order,
  output logic [2:0]           first_err_code,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [31:0]          retire_count,
  output logic                 halted
);

  state_e      state;
  logic [63:0] exp_order;
  logic [31:0] prev_pc;
  logic        prev_trap;

  logic [31:0] rs1_val, rs2_val;
  logic        rs1_known, rs2_known;
  logic        in_halt, shadow_we;
  logic        order_bad, pc_bad, rs1_bad, rs2_bad, x0_bad;
  err_code_e   chk_code;
  logic        fail;

  always_comb begin
    in_halt   = (state == ST_HALTED);
    order_bad = (rvfi_order != exp_order);
    pc_bad    = (CHECK_PC != 0) && (state == ST_RUN) && !rvfi_intr && !prev_trap &&
                (rvfi_pc_rdata != prev_pc);
    rs1_bad   = !rvfi_trap && rs1_known && (rvfi_rs1_rdata != rs1_val);
    rs2_bad   = !rvfi_trap && rs2_known && (rvfi_rs2_rdata != rs2_val);
    x0_bad    = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);
    shadow_we = rvfi_valid && !in_halt && !rvfi_trap;

    // Lowest code wins; after halt nothing but POST_HALT is reported
    chk_code = ERR_NONE;
    if (in_halt)        chk_code = ERR_POST_HALT;
    else if (order_bad) chk_code = ERR_ORDER;
    else if (pc_bad)    chk_code = ERR_PC;
    else if (rs1_bad)   chk_code = ERR_RS1;
    else if (rs2_bad)   chk_code = ERR_RS2;
    else if (x0_bad)    chk_code = ERR_X0_WRITE;
    fail = rvfi_valid && (chk_code != ERR_NONE);
  end

  rvfi_shadow_rf u_shadow_rf (
    .clk     (clk),
    .resetn  (resetn),
    .we      (shadow_we),
    .waddr   (rvfi_rd_addr),
    .wdata   (rvfi_rd_wdata),
    .raddr1  (rvfi_rs1_addr),
    .rdata1  (rs1_val),
    .rknown1 (rs1_known),
    .raddr2  (rvfi_rs2_addr),
    .rdata2  (rs2_val),
    .rknown2 (rs2_known)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      exp_order      <= 64'd0;
      prev_pc        <= 32'd0;
      prev_trap      <= 1'b0;
      err_valid      <= 1'b0;
      err_code       <= 3'd0;
      err_order      <= 64'd0;
      first_err_code <= 3'd0;
      err_count      <= '0;
      retire_count   <= 32'd0;
    end else begin
      err_valid <= fail;
      err_code  <= fail ? chk_code : ERR_NONE;
      err_order <= fail ? rvfi_order : 64'd0;
      if (fail && first_err_code == 3'd0) first_err_code <= chk_code;
      if (fail && err_count != {ERR_CNT_W{1'b1}}) err_count <= err_count + 1'b1;
      if (rvfi_valid) begin
        exp_order <= rvfi_order + 64'd1;
        if (!in_halt) begin
          prev_pc      <= rvfi_pc_wdata;
          prev_trap    <= rvfi_trap;
          retire_count <= retire_count + 32'd1;
          state        <= rvfi_halt ? ST_HALTED : ST_RUN;
        end
      end
    end
  end

  assign halted = (state == ST_HALTED);

endmodule

// File: tb/tb_rvfi_reg_checker.sv
// tb/tb_rvfi_reg_checker.sv - directed self-checking bench for rvfi_reg_checker
module tb_rvfi_reg_checker;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
  logic [63:0] rvfi_order;
  logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata;
  logic        err_valid, halted;
  logic [2:0]  err_code, first_err_code;
  logic [63:0] err_order;
  logic [15:0] err_count;
  logic [31:0] retire_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rvfi_reg_checker #(.CHECK_PC(1), .ERR_CNT_W(16)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .rvfi_valid     (rvfi_valid),
    .rvfi_order     (rvfi_order),
    .rvfi_trap      (rvfi_trap),
    .rvfi_halt      (rvfi_halt),
    .rvfi_intr      (rvfi_intr),
    .rvfi_rs1_addr  (rvfi_rs1_addr),
    .rvfi_rs2_addr  (rvfi_rs2_addr),
    .rvfi_rs1_rdata (rvfi_rs1_rdata),
    .rvfi_rs2_rdata (rvfi_rs2_rdata),
    .rvfi_rd_addr   (rvfi_rd_addr),
    .rvfi_rd_wdata  (rvfi_rd_wdata),
    .rvfi_pc_rdata  (rvfi_pc_rdata),
    .rvfi_pc_wdata  (rvfi_pc_wdata),
    .err_valid      (err_valid),
    .err_code       (err_code),
    .err_order      (err_order),
    .first_err_code (first_err_code),
    .err_count      (err_count),
    .retire_count   (retire_count),
    .halted         (halted)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rvfi_valid = 0; rvfi_order = 0; rvfi_trap = 0; rvfi_halt = 0; rvfi_intr = 0;
    rvfi_rs1_addr = 0; rvfi_rs2_addr = 0; rvfi_rs1_rdata = 0; rvfi_rs2_rdata = 0;
    rvfi_rd_addr = 0; rvfi_rd_wdata = 0; rvfi_pc_rdata = 0; rvfi_pc_wdata = 0;
  endtask

  // Presents one retirement starting at a negedge; returns at the next negedge,
  // where the registered error outputs describe this retirement.
  task automatic retire(input logic [63:0] order, input logic [31:0] pcr, input logic [31:0] pcw,
                        input logic [4:0] rd, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] a2, input logic [31:0] d2,
                        input logic trap, input logic halt, input logic intr);
    rvfi_valid = 1; rvfi_order = order; rvfi_pc_rdata = pcr; rvfi_pc_wdata = pcw;
    rvfi_rd_addr = rd; rvfi_rd_wdata = wd; rvfi_rs1_addr = a1; rvfi_rs1_rdata = d1;
    rvfi_rs2_addr = a2; rvfi_rs2_rdata = d2; rvfi_trap = trap; rvfi_halt = halt; rvfi_intr = intr;
    @(negedge clk);
  endtask

  task automatic idle();
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".err_valid"}, 64'(err_valid), 64'd0);
    check({tag, ".err_code"}, 64'(err_code), 64'd0);
    check({tag, ".err_order"}, err_order, 64'd0);
    check({tag, ".first_err_code"}, 64'(first_err_code), 64'd0);
    check({tag, ".err_count"}, 64'(err_count), 64'd0);
    check({tag, ".retire_count"}, 64'(retire_count), 64'd0);
    check({tag, ".halted"}, 64'(halted), 64'd0);
  endtask

  task automatic reset_pulse(input string tag);
    clear_inputs();
    resetn = 0;
    #1;
    check_all_zero(tag);
    @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    resetn = 0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    resetn = 1;

    // clean run: x1=0xA, x2=0xB, then read them back
    retire(0, 32'h0, 32'h4, 5'd1, 32'hA, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
    check("clean0.err_valid", 64'(err_valid), 64'd0);
    retire(1, 32'h4, 32'h8, 5'd2, 32'hB, 5'd1, 32'hA, 5'd0, 32'd0, 0, 0, 0);
    check("clean1.err_valid", 64'(err_valid), 64'd0);
    retire(2, 32'h8, 32'hC, 5'd0, 32'd0, 5'd2, 32'hB, 5'd1, 32'hA, 0, 0, 0);
    check("clean2.err_valid", 64'(err_valid), 64'd0);
    check("clean.retire_count", 64'(retire_count), 64'd3);
    check("clean.err_count", 64'(err_count), 64'd0);
    check("clean.first_err_code", 64'(first_err_code), 64'd0);

    // back-to-back write x5 then stale read of x5
    retire(3, 32'hC, 32'h10, 5'd5, 32'h1234, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
    check("rs1_wr.err_valid", 64'(err_valid), 64'd0);
    retire(4, 32'h10, 32'h14, 5'd0, 32'd0, 5'd5, 32'h1235, 5'd0, 32'd0, 0, 0, 0);
    check("rs1.err_valid", 64'(err_valid), 64'd1);
    check("rs1.err_code", 64'(err_code), 64'd3);
    check("rs1.err_order", err_order, 64'd4);
    check("rs1.err_count", 64'(err_count), 64'd1);
    check("rs1.first_err_code", 64'(first_err_code), 64'd3);
    idle();
    check("rs1.pulse_len", 64'(err_valid), 64'd0);

    // order gap 5,6,8 then 9
    retire(5, 32'h14, 32'h18, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
    retire(6, 32'h18, 32'h1C, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
    check("ord_ok.err_valid", 64'(err_valid), 64'd0);
    retire(8, 32'h1C, 32'h20, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
    check("ord.err_valid", 64'(err_valid), 64'd1);
    check("ord.err_code", 64'(err_code), 64'd1);
    check("ord.err_order", err_order, 64'd8);
    retire(9, 32'h20, 32'h24, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
    check("ord_next.err_valid", 64'(err_valid), 64'd0);
    check("ord.err_count", 64'(err_count), 64'd2);

    // PC discontinuity, then an interrupt-entry jump that must be tolerated
    retire(10, 32'h24, 32'h100, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
    retire(11, 32'h200, 32'h204, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
    check("pc.err_valid", 64'(err_valid), 64'd1);
    check("pc.err_code", 64'(err_code), 64'd2);
    retire(12, 32'h300, 32'h304, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 1);
    check("pc_intr.err_valid", 64'(err_valid), 64'd0);

    // RS2 against known x5
    retire(13, 32'h304, 32'h308, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 32'h1234, 0, 0, 0);
    check("rs2_ok.err_valid", 64'(err_valid), 64'd0);
    retire(14, 32'h308, 32'h30C, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 32'h0, 0, 0, 0);
    check("rs2.err_code", 64'(err_code), 64'd4);
    check("rs2.err_count", 64'(err_count), 64'd4);

    // trapped: rs not checked, x6 not written; next PC not checked, x6 still unknown
    retire(15, 32'h30C, 32'h310, 5'd6, 32'h7, 5'd5, 32'hDEAD, 5'd0, 32'd0, 1, 0, 0);
    check("trap.err_valid", 64'(err_valid), 64'd0);
    retire(16, 32'h999, 32'h99D, 5'd0, 32'd0, 5'd6, 32'h55, 5'd0, 32'd0, 0, 0, 0);
    check("after_trap.err_valid", 64'(err_valid), 64'd0);
    check("run.first_err_code", 64'(first_err_code), 64'd3);
    idle();

    // mid-run reset; order and x0-write fail together -> lowest code
    reset_pulse("midreset");
    retire(5, 32'h40, 32'h44, 5'd0, 32'h1, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
    check("multi.err_code", 64'(err_code), 64'd1);
    check("multi.err_count", 64'(err_count), 64'd1);
    check("multi.first_err_code", 64'(first_err_code), 64'd1);
    retire(6, 32'h44, 32'h48, 5'd0, 32'h1, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
    check("x0.err_code", 64'(err_code), 64'd5);
    check("x0.first_err_code", 64'(first_err_code), 64'd1);
    check("x0.retire_count", 64'(retire_count), 64'd2);

    // halt, then a stray retirement with a bad order still reports POST_HALT
    retire(7, 32'h48, 32'h4C, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 1, 0);
    check("halt.err_valid", 64'(err_valid), 64'd0);
    check("halt.halted", 64'(halted), 64'd1);
    retire(99, 32'h4C, 32'h50, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
    check("post_halt.err_code", 64'(err_code), 64'd6);
    check("post_halt.err_order", err_order, 64'd99);
    check("post_halt.err_count", 64'(err_count), 64'd3);
    check("post_halt.halted", 64'(halted), 64'd1);
    idle();
    reset_pulse("final_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
